// File: rtl/thread_issue_scheduler.sv
// ----------------------------------------------------------------------------
// thread_issue_scheduler
//
// Purpose:
//   Picks one ready hardware thread per cycle, round-robin, and registers that
//   thread's instruction toward decode. Each thread has a small state machine
//   (RUNNING / SUSPENDED / RECOVER). A hazard shift register stops a
//   single-cycle instruction from colliding with an earlier long-latency
//   instruction at the writeback merge.
//
// Handshake (ts_* -> decode):
//   The output register holds one entry, and ts_valid marks it as real.
//   Decode takes the entry on any clock edge where ds_ready is high. The
//   register may load a new entry only when it is empty or being taken
//   (advance = ds_ready | ~ts_valid). While advance is low, everything toward
//   decode holds, no thread is granted, and the hazard register freezes.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   thread_enable[N]      per-thread enable from control registers
//   if_valid[N]           fetch holds an instruction for thread i
//   if_instruction[N*W]   instructions, thread 0 at the LSBs
//   if_pc[N*32]           PCs, thread 0 at the LSBs
//   if_long_latency[N]    instruction i uses the multi-cycle pipe
//   ts_instruction_req[N] combinational grant pulse: fetch advances thread i
//   rb_rollback[N]        rollback thread i
//   rb_suspend[N]         suspend thread i (cache miss)
//   resume[N]             wake suspended thread i
//   ds_ready              decode accepts the output register this cycle
//   ts_valid, ts_instruction, ts_pc, ts_thread, ts_long_latency
//                         registered issue slot
//   pc_event_issue        combinational pulse per issued instruction
//   o_dbg_thread_state    thread state machines, 2 bits per thread
//                         (0 RUNNING, 1 SUSPENDED, 2 RECOVER)
//   issue_count[N*32]     per-thread grant counters; present only when
//                         ISSUE_COUNTERS_EN is defined
// ----------------------------------------------------------------------------
module thread_issue_scheduler #(
    parameter int NUM_THREADS = 4,
    parameter int INSTR_WIDTH = 32,
    parameter int LL_DEPTH    = 3,
    parameter logic [INSTR_WIDTH-1:0] NOP_VALUE = '0,
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_THREADS-1:0]          thread_enable,
    input  logic [NUM_THREADS-1:0]          if_valid,
    input  logic [NUM_THREADS*INSTR_WIDTH-1:0] if_instruction,
    input  logic [NUM_THREADS*32-1:0]       if_pc,
    input  logic [NUM_THREADS-1:0]          if_long_latency,
    output logic [NUM_THREADS-1:0]          ts_instruction_req,
    input  logic [NUM_THREADS-1:0]          rb_rollback,
    input  logic [NUM_THREADS-1:0]          rb_suspend,
    input  logic [NUM_THREADS-1:0]          resume,
    input  logic                            ds_ready,
    output logic                            ts_valid,
    output logic [INSTR_WIDTH-1:0]          ts_instruction,
    output logic [31:0]                     ts_pc,
    output logic [TW-1:0]                   ts_thread,
    output logic                            ts_long_latency,
    output logic                            pc_event_issue,
`ifdef ISSUE_COUNTERS_EN
    output logic [NUM_THREADS*32-1:0]       issue_count,
`endif
    output logic [NUM_THREADS*2-1:0]        o_dbg_thread_state
);

    typedef enum logic [1:0] {
        ST_RUNNING   = 2'd0,
        ST_SUSPENDED = 2'd1,
        ST_RECOVER   = 2'd2
    } thread_state_t;

    thread_state_t           r_state [NUM_THREADS];
    logic [TW-1:0]           r_ptr;
    logic [LL_DEPTH-1:0]     r_hz;

    logic                    w_advance;
    logic [NUM_THREADS-1:0]  w_eligible;
    logic [NUM_THREADS-1:0]  w_grant;
    logic                    w_grant_any;
    logic [TW-1:0]           w_grant_idx;
    int                      w_scan_idx;
    logic                    w_sel_ll;
    logic [LL_DEPTH:0]       w_hz_shift;

    assign w_advance = ds_ready | ~ts_valid;

    // While the oldest long-latency result is due at the merge, only another
    // long-latency instruction may issue this cycle.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_eligible[i] = (r_state[i] == ST_RUNNING) & thread_enable[i] & if_valid[i]
                          & ~rb_rollback[i] & ~rb_suspend[i]
                          & ~(r_hz[LL_DEPTH-1] & ~if_long_latency[i]);
        end
    end

    // Round-robin search starting at the pointer; the first eligible thread wins.
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = 0;
        if (w_advance) begin
            for (int k = 0; k < NUM_THREADS; k++) begin
                w_scan_idx = int'(r_ptr) + k;
                if (w_scan_idx >= NUM_THREADS) begin
                    w_scan_idx = w_scan_idx - NUM_THREADS;
                end
                if (!w_grant_any && w_eligible[w_scan_idx]) begin
                    w_grant[w_scan_idx] = 1'b1;
                    w_grant_any         = 1'b1;
                    w_grant_idx         = TW'(w_scan_idx);
                end
            end
        end
    end

    assign w_sel_ll           = if_long_latency[w_grant_idx];
    assign ts_instruction_req = w_grant;
    assign pc_event_issue     = w_grant_any;

    // One bit wider than the register, so the shift also works when LL_DEPTH is 1.
    assign w_hz_shift = {r_hz, w_grant_any & w_sel_ll};

    // Per-thread state machines. Rollback has priority over suspend, and
    // suspend has priority over resume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                r_state[i] <= ST_RUNNING;
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (rb_rollback[i]) begin
                    r_state[i] <= ST_RECOVER;
                end else begin
                    case (r_state[i])
                        ST_RUNNING:   if (rb_suspend[i]) r_state[i] <= ST_SUSPENDED;
                        ST_SUSPENDED: if (!rb_suspend[i] && resume[i]) r_state[i] <= ST_RUNNING;
                        ST_RECOVER:   r_state[i] <= ST_RUNNING;
                        default:      r_state[i] <= ST_RUNNING;
                    endcase
                end
            end
        end
    end

    always_comb begin
        o_dbg_thread_state = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            o_dbg_thread_state[2*i +: 2] = r_state[i];
        end
    end

    // Arbiter pointer and hazard register; both hold while decode stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_hz  <= '0;
        end else if (w_advance) begin
            r_hz <= w_hz_shift[LL_DEPTH-1:0];
            if (w_grant_any) begin
                r_ptr <= (int'(w_grant_idx) == NUM_THREADS - 1) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    // Issue register toward decode. A rollback of the held thread does not
    // cancel the held entry; downstream squashes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_valid        <= 1'b0;
            ts_instruction  <= NOP_VALUE;
            ts_pc           <= '0;
            ts_thread       <= '0;
            ts_long_latency <= 1'b0;
        end else if (w_advance) begin
            if (w_grant_any) begin
                ts_valid        <= 1'b1;
                ts_instruction  <= if_instruction[w_grant_idx*INSTR_WIDTH +: INSTR_WIDTH];
                ts_pc           <= if_pc[w_grant_idx*32 +: 32];
                ts_thread       <= w_grant_idx;
                ts_long_latency <= w_sel_ll;
            end else begin
                ts_valid        <= 1'b0;
                ts_instruction  <= NOP_VALUE;
                ts_pc           <= '0;
                ts_thread       <= '0;
                ts_long_latency <= 1'b0;
            end
        end
    end

`ifdef ISSUE_COUNTERS_EN
    logic [31:0] r_issue_count [NUM_THREADS];

    // Free-running counters; each wraps at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                r_issue_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (w_grant[i]) begin
                    r_issue_count[i] <= r_issue_count[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        issue_count = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            issue_count[i*32 +: 32] = r_issue_count[i];
        end
    end
`endif

endmodule

// File: doc/thread_issue_scheduler.md
Name: thread_issue_scheduler

Overview:
Parametrised successor to the strand select stage. Each cycle it picks one ready hardware thread, round-robin, and registers that thread's instruction to the decode stage. It tracks per-thread suspend/rollback state and blocks issue that would collide with a long-latency instruction at the execute writeback merge; the long-latency depth is configurable. Unlike its predecessor, it honours a decode back-pressure handshake.

Parameters:
NUM_THREADS, 4, number of hardware threads (1..16)
INSTR_WIDTH, 32, instruction width in bits
LL_DEPTH, 3, stages by which the long-latency pipe exceeds the single-cycle pipe (1..8)
NOP_VALUE, 0, instruction word driven when no valid issue

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
thread_enable  in  NUM_THREADS  per-thread enable from control registers
if_valid  in  NUM_THREADS  fetch has an instruction for thread i
if_instruction  in  NUM_THREADS*INSTR_WIDTH  concatenated instructions, thread 0 at LSBs
if_pc  in  NUM_THREADS*32  concatenated PCs
if_long_latency  in  NUM_THREADS  instruction i uses the multi-cycle pipe
ts_instruction_req  out  NUM_THREADS  one-cycle pulse: fetch must advance thread i
rb_rollback  in  NUM_THREADS  rollback thread i
rb_suspend  in  NUM_THREADS  suspend thread i (cache miss)
resume  in  NUM_THREADS  wake suspended thread i
ds_ready  in  1  decode accepts the output register this cycle
ts_valid  out  1  output register holds a real instruction
ts_instruction  out  INSTR_WIDTH  issued instruction
ts_pc  out  32  issued PC
ts_thread  out  max(1,clog2(NUM_THREADS))  issued thread index
ts_long_latency  out  1  issued instruction is long latency
pc_event_issue  out  1  pulse per issued instruction

Behaviour:
- Reset values: thread FSMs RUNNING; arbiter pointer 0; hazard shift register 0; ts_valid 0; ts_instruction NOP_VALUE; ts_pc 0; ts_thread 0; ts_long_latency 0. All outputs are registered except ts_instruction_req and pc_event_issue.
- Per-thread FSM states: RUNNING, SUSPENDED, RECOVER.
  - RUNNING goes to SUSPENDED on rb_suspend.
  - SUSPENDED goes to RUNNING on resume.
  - Any state goes to RECOVER on rb_rollback. RECOVER goes to RUNNING after exactly one cycle.
  - Priority: rollback > suspend > resume.
  - resume in RUNNING or RECOVER is ignored.
  - resume and suspend in the same cycle while RUNNING: thread goes to SUSPENDED.
- Eligibility: eligible[i] = RUNNING & thread_enable[i] & if_valid[i] & ~rb_rollback[i] & ~rb_suspend[i] & ~(hz[LL_DEPTH-1] & ~if_long_latency[i]).
- advance = ds_ready | ~ts_valid. Grant occurs only when advance is 1. The grant is one-hot.
- Arbiter: round-robin, starting the search at the pointer. After any grant, the pointer becomes (granted index + 1) mod NUM_THREADS. With no grant, the pointer holds.
- On a grant:
  - Output registers load the selected thread's fields; ts_valid is 1.
  - ts_instruction_req[g] pulses in the same cycle.
  - pc_event_issue is 1.
- When advance is 1 with no grant: ts_valid 0, ts_instruction NOP_VALUE, ts_pc 0, ts_thread 0, ts_long_latency 0.
- When advance is 0: all output registers hold, no grant is made, and the hazard register holds.
- Hazard register hz[LL_DEPTH-1:0]: on advance, hz shifts left with bit 0 = (grant & selected long-latency). It is frozen otherwise.
- Latency: eligible-to-output is 1 cycle.
- A rollback arriving while the thread is the held (stalled) output does not cancel the held output; the rollback controller squashes it downstream.
- Reset asserted mid-operation: immediate return to reset values; pending rollbacks are lost.

Optional Feature:
ISSUE_COUNTERS_EN
- Defined: adds output issue_count, width NUM_THREADS*32. It holds per-thread 32-bit counters, reset to 0, incremented on each grant of that thread, wrapping at 2^32.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Round robin: NUM_THREADS=4, all enabled and valid, short latency, ds_ready=1 → ts_thread sequence 0,1,2,3,0 on consecutive cycles; ts_instruction_req pulses match.
- Hazard blocking: LL_DEPTH=3, thread0 long latency issued at cycle t, other threads short only → no grant at cycle t+3 (ts_valid=0 at t+4); a long-latency thread is still granted at t+3.
- Back-pressure: ds_ready=0 for 5 cycles with ts_valid=1 → outputs stable, ts_instruction_req=0, hz frozen; ds_ready=1 → next thread issues the following cycle.
- Suspend/resume: rb_suspend[2] at t → thread 2 is never granted until resume[2]; simultaneous suspend+resume leaves thread 2 suspended; rollback on a suspended thread gives RECOVER for 1 cycle, then eligible.
- Idle: thread_enable=0 → ts_valid=0, ts_instruction=NOP_VALUE, pc_event_issue=0.
- With ISSUE_COUNTERS_EN: 10 grants of thread 1 → issue_count[63:32]=10; reset mid-run → all counters 0.
